// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first, with gapless reload
//
// Purpose: accepts a WIDTH-bit word through a valid/ready handshake and
// emits it one bit per clock, MSB first. A new word can be taken on the
// last bit of the current one, so consecutive words stream without a gap.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous, active-low reset
//   load_valid - data_in holds a word to transmit
//   data_in    - parallel word, sampled only on an accepted load
//   load_ready - block accepts a word this cycle (combinational)
//   ser_out    - serial data bit, MSB first
//   ser_valid  - ser_out carries a valid bit this cycle
//   done       - one-cycle pulse on the last bit of a word
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             w_last;
  logic             w_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_shreg <= w_shreg_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_cnt_next   = r_cnt;

    // The counter reaching zero marks the bit currently on ser_out as the
    // last of its word; that is the only SHIFT cycle open to a new load.
    w_last     = (r_state == SHIFT) && (r_cnt == '0);
    load_ready = (r_state == IDLE) || w_last;
    w_load     = load_valid && load_ready;

    ser_valid  = (r_state == SHIFT);
    ser_out    = (r_state == SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
    done       = w_last;

    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_next = SHIFT;
          w_shreg_next = data_in;
          w_cnt_next   = LAST_CNT;
        end
      end
      SHIFT: begin
        if (w_load) begin
          // Reload on the last bit keeps the stream gapless.
          w_shreg_next = data_in;
          w_cnt_next   = LAST_CNT;
        end else if (w_last) begin
          w_state_next = IDLE;
          w_shreg_next = '0;
          w_cnt_next   = '0;
        end else begin
          w_shreg_next = {r_shreg[WIDTH-2:0], 1'b0};
          w_cnt_next   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
